// File: rtl/decode_exec_latch.sv
// Decode-to-execute pipeline register for the rv32i core: load-use bubbles, memory-stall freeze,
// flush kill and capture of forwarded operands. Optional perf counters: DEC_EXEC_PERF_CNT_EN.

package rv32i_types;
    typedef logic [6:0] rv32i_opcode;
endpackage

module decode_exec_latch
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [31:0] dec_pc,
    input  logic [31:0] dec_imm,
    input  rv32i_opcode dec_opcode,
    input  logic [2:0]  dec_funct3,
    input  logic [4:0]  dec_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_regld,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic        rs1_fwd_sel,
    input  logic        rs2_fwd_sel,
    input  logic [31:0] rs1_data_forward,
    input  logic [31:0] rs2_data_forward,
    input  logic        hazard_stall_signal,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic        ex_regld,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output rv32i_opcode ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
`ifdef DEC_EXEC_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_count,
`endif
    output logic        dec_ready
);

    typedef enum logic [1:0] {ST_RUN, ST_LUSE, ST_FREEZE} state_t;

    state_t      state_q, state_d;
    logic        ex_valid_q, ex_valid_d, ex_regld_q, ex_regld_d;
    logic [31:0] ex_pc_q, ex_pc_d, ex_imm_q, ex_imm_d;
    logic [31:0] ex_rs1_data_q, ex_rs1_data_d, ex_rs2_data_q, ex_rs2_data_d;
    rv32i_opcode ex_opcode_q, ex_opcode_d;
    logic [2:0]  ex_funct3_q, ex_funct3_d;
    logic [4:0]  ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic        cap_v1_q, cap_v1_d, cap_v2_q, cap_v2_d;
    logic [31:0] cap_rs1_q, cap_rs1_d, cap_rs2_q, cap_rs2_d;
    logic        flush_pend_q, flush_pend_d;
    logic [31:0] op1_sel, op2_sel;
    logic        flush_now, bubble_wr;

    // Captures are only ever valid outside RUN: every transition into RUN clears them.
    always_comb begin
        op1_sel = rf_rs1_data;
        if (dec_rs1 != 5'd0) begin
            if (rs1_fwd_sel)                          op1_sel = rs1_data_forward;
            else if (cap_v1_q && state_q != ST_RUN)   op1_sel = cap_rs1_q;
        end
        op2_sel = rf_rs2_data;
        if (dec_rs2 != 5'd0) begin
            if (rs2_fwd_sel)                          op2_sel = rs2_data_forward;
            else if (cap_v2_q && state_q != ST_RUN)   op2_sel = cap_rs2_q;
        end
    end

    assign flush_now = !mem_stall && (flush || flush_pend_q);
    assign bubble_wr = !mem_stall && (flush_now || !hazard_stall_signal);
    assign dec_ready = !mem_stall && hazard_stall_signal && !flush_pend_q;

    always_comb begin
        state_d       = state_q;
        ex_valid_d    = ex_valid_q;
        ex_regld_d    = ex_regld_q;
        ex_pc_d       = ex_pc_q;
        ex_imm_d      = ex_imm_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_opcode_d   = ex_opcode_q;
        ex_funct3_d   = ex_funct3_q;
        ex_rd_d       = ex_rd_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        cap_v1_d      = cap_v1_q;
        cap_v2_d      = cap_v2_q;
        cap_rs1_d     = cap_rs1_q;
        cap_rs2_d     = cap_rs2_q;
        flush_pend_d  = flush_pend_q;

        if (mem_stall || (!flush_now && !hazard_stall_signal)) begin
            if (rs1_fwd_sel && dec_rs1 != 5'd0) begin
                cap_rs1_d = rs1_data_forward;
                cap_v1_d  = 1'b1;
            end
            if (rs2_fwd_sel && dec_rs2 != 5'd0) begin
                cap_rs2_d = rs2_data_forward;
                cap_v2_d  = 1'b1;
            end
        end

        if (mem_stall) begin
            state_d = ST_FREEZE;
            if (flush) flush_pend_d = 1'b1;
        end else if (flush_now) begin
            ex_valid_d   = 1'b0;
            ex_regld_d   = 1'b0;
            ex_rd_d      = 5'd0;
            cap_v1_d     = 1'b0;
            cap_v2_d     = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = ST_RUN;
        end else if (!hazard_stall_signal) begin
            ex_valid_d = 1'b0;
            ex_regld_d = 1'b0;
            ex_rd_d    = 5'd0;
            state_d    = ST_LUSE;
        end else begin
            ex_valid_d    = dec_valid;
            ex_regld_d    = dec_regld && dec_valid;
            ex_pc_d       = dec_pc;
            ex_imm_d      = dec_imm;
            ex_rs1_data_d = op1_sel;
            ex_rs2_data_d = op2_sel;
            ex_opcode_d   = dec_opcode;
            ex_funct3_d   = dec_funct3;
            ex_rd_d       = dec_rd;
            ex_rs1_d      = dec_rs1;
            ex_rs2_d      = dec_rs2;
            cap_v1_d      = 1'b0;
            cap_v2_d      = 1'b0;
            state_d       = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            ex_valid_q    <= 1'b0;
            ex_regld_q    <= 1'b0;
            ex_pc_q       <= 32'd0;
            ex_imm_q      <= 32'd0;
            ex_rs1_data_q <= 32'd0;
            ex_rs2_data_q <= 32'd0;
            ex_opcode_q   <= 7'b0;
            ex_funct3_q   <= 3'd0;
            ex_rd_q       <= 5'd0;
            ex_rs1_q      <= 5'd0;
            ex_rs2_q      <= 5'd0;
            cap_v1_q      <= 1'b0;
            cap_v2_q      <= 1'b0;
            cap_rs1_q     <= 32'd0;
            cap_rs2_q     <= 32'd0;
            flush_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ex_valid_q    <= ex_valid_d;
            ex_regld_q    <= ex_regld_d;
            ex_pc_q       <= ex_pc_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_funct3_q   <= ex_funct3_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            cap_v1_q      <= cap_v1_d;
            cap_v2_q      <= cap_v2_d;
            cap_rs1_q     <= cap_rs1_d;
            cap_rs2_q     <= cap_rs2_d;
            flush_pend_q  <= flush_pend_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_regld    = ex_regld_q;
    assign ex_pc       = ex_pc_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_opcode   = ex_opcode_q;
    assign ex_funct3   = ex_funct3_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;

`ifdef DEC_EXEC_PERF_CNT_EN
    logic [31:0] stall_cycles_q, bubble_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            bubble_count_q <= 32'd0;
        end else begin
            if (!dec_ready) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (bubble_wr)  bubble_count_q <= bubble_count_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign bubble_count = bubble_count_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble_wr;
`endif

endmodule

// File: tb/tb_decode_exec_latch.sv
// Directed bench for decode_exec_latch: forwarding, load-use bubbles, captures, freeze, flush, reset.
// Counter checks are active when DEC_EXEC_PERF_CNT_EN is defined.

module tb_decode_exec_latch;

    logic        clk, rst;
    logic        dec_valid, dec_regld;
    logic [31:0] dec_pc, dec_imm;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] rf_rs1_data, rf_rs2_data, rs1_data_forward, rs2_data_forward;
    logic        rs1_fwd_sel, rs2_fwd_sel, hazard_stall_signal, mem_stall, flush;
    logic        dec_ready, ex_valid, ex_regld;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
`ifdef DEC_EXEC_PERF_CNT_EN
    logic [31:0] stall_cycles, bubble_count;
    logic [31:0] sc0, bc0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    decode_exec_latch dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_imm(dec_imm),
        .dec_opcode(dec_opcode), .dec_funct3(dec_funct3),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_regld(dec_regld),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
        .rs1_data_forward(rs1_data_forward), .rs2_data_forward(rs2_data_forward),
        .hazard_stall_signal(hazard_stall_signal), .mem_stall(mem_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_regld(ex_regld), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
`ifdef DEC_EXEC_PERF_CNT_EN
        .stall_cycles(stall_cycles), .bubble_count(bubble_count),
`endif
        .dec_ready(dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        dec_valid = 0; dec_regld = 0; dec_pc = 0; dec_imm = 0; dec_opcode = 0; dec_funct3 = 0;
        dec_rd = 0; dec_rs1 = 0; dec_rs2 = 0; rf_rs1_data = 0; rf_rs2_data = 0;
        rs1_fwd_sel = 0; rs2_fwd_sel = 0; rs1_data_forward = 0; rs2_data_forward = 0;
        hazard_stall_signal = 1; mem_stall = 0; flush = 0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        dec_valid = 1; dec_regld = 1; dec_pc = pc; dec_opcode = op; dec_funct3 = 3'd0;
        dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2; dec_imm = imm;
    endtask

    task automatic test_reset();
        rst = 1;
        set_idle();
        set_instr(32'h0000_0ABC, OP_REG, 5'd7, 5'd1, 5'd2, 32'h55);
        #2;
        tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ex_valid got %0b exp 0", ex_valid); end
        tests_run++; if (ex_opcode !== 7'd0) begin tests_failed++; $display("FAIL reset_ex_opcode got %h exp 00", ex_opcode); end
        tick();
        tests_run++; if (ex_pc !== 32'd0) begin tests_failed++; $display("FAIL reset_ex_pc_hold got %h exp 0", ex_pc); end
        tests_run++; if (ex_rd !== 5'd0) begin tests_failed++; $display("FAIL reset_ex_rd got %0d exp 0", ex_rd); end
`ifdef DEC_EXEC_PERF_CNT_EN
        tests_run++; if (stall_cycles !== 32'd0 || bubble_count !== 32'd0) begin tests_failed++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, bubble_count); end
`endif
        rst = 0;
        set_idle();
        #1;
        tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_dec_ready got %0b exp 1", dec_ready); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_back_to_back();
        set_idle();
        set_instr(32'h100, OP_IMM, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        tests_run++; if (ex_pc !== 32'h100 || ex_valid !== 1'b1 || ex_imm !== 32'd5) begin tests_failed++; $display("FAIL b2b_addi pc/valid/imm got %h/%0b/%h exp 100/1/5", ex_pc, ex_valid, ex_imm); end
        tests_run++; if (ex_rd !== 5'd1 || ex_regld !== 1'b1) begin tests_failed++; $display("FAIL b2b_addi rd/regld got %0d/%0b exp 1/1", ex_rd, ex_regld); end
        set_instr(32'h104, OP_REG, 5'd2, 5'd1, 5'd1, 32'd0);
        rf_rs1_data = 32'h11; rf_rs2_data = 32'h22;
        rs1_fwd_sel = 1; rs2_fwd_sel = 1; rs1_data_forward = 32'h5; rs2_data_forward = 32'h5;
        tick();
        tests_run++; if (ex_rs1_data !== 32'h5 || ex_rs2_data !== 32'h5) begin tests_failed++; $display("FAIL b2b_add_fwd got %h/%h exp 5/5", ex_rs1_data, ex_rs2_data); end
        tests_run++; if (ex_pc !== 32'h104 || ex_valid !== 1'b1 || ex_opcode !== OP_REG) begin tests_failed++; $display("FAIL b2b_add pc/valid/op got %h/%0b/%h exp 104/1/33", ex_pc, ex_valid, ex_opcode); end
        set_idle();
        dec_regld = 1; dec_rd = 5'd9;
        tick();
        tests_run++; if (ex_valid !== 1'b0 || ex_regld !== 1'b0) begin tests_failed++; $display("FAIL b2b_invalid_regld got %0b/%0b exp 0/0", ex_valid, ex_regld); end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_load_use_one();
        set_idle();
        set_instr(32'h200, OP_LOAD, 5'd3, 5'd0, 5'd0, 32'd0);
        tick();
`ifdef DEC_EXEC_PERF_CNT_EN
        sc0 = stall_cycles; bc0 = bubble_count;
`endif
        set_instr(32'h204, OP_REG, 5'd4, 5'd3, 5'd0, 32'd0);
        hazard_stall_signal = 0;
        #1;
        tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL lu1_dec_ready got %0b exp 0", dec_ready); end
        tick();
        tests_run++; if (ex_valid !== 1'b0 || ex_regld !== 1'b0 || ex_rd !== 5'd0) begin tests_failed++; $display("FAIL lu1_bubble valid/regld/rd got %0b/%0b/%0d exp 0/0/0", ex_valid, ex_regld, ex_rd); end
        hazard_stall_signal = 1; rs1_fwd_sel = 1; rs1_data_forward = 32'h1234;
        tick();
        tests_run++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || ex_rd !== 5'd4) begin tests_failed++; $display("FAIL lu1_add valid/pc/rd got %0b/%h/%0d exp 1/204/4", ex_valid, ex_pc, ex_rd); end
        tests_run++; if (ex_rs1_data !== 32'h1234 || ex_rs2_data !== 32'd0) begin tests_failed++; $display("FAIL lu1_add_ops got %h/%h exp 1234/0", ex_rs1_data, ex_rs2_data); end
`ifdef DEC_EXEC_PERF_CNT_EN
        tests_run++; if (bubble_count !== bc0 + 32'd1 || stall_cycles !== sc0 + 32'd1) begin tests_failed++; $display("FAIL lu1_counters got %0d/%0d exp %0d/%0d", bubble_count, stall_cycles, bc0 + 1, sc0 + 1); end
`endif
        $display("[TB] test_load_use_one done");
    endtask

    task automatic test_load_use_two();
        set_idle();
        set_instr(32'h300, OP_REG, 5'd5, 5'd3, 5'd0, 32'd0);
        hazard_stall_signal = 0; rs1_fwd_sel = 1; rs1_data_forward = 32'hDEADBEEF;
        rs2_fwd_sel = 1; rs2_data_forward = 32'h0BAD;
        tick();
        tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL lu2_bubble1 got %0b exp 0", ex_valid); end
        rs1_fwd_sel = 0; rs1_data_forward = 32'h0;
        tick();
        tests_run++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin tests_failed++; $display("FAIL lu2_bubble2 got %0b/%0d exp 0/0", ex_valid, ex_rd); end
        hazard_stall_signal = 1;
        tick();
        tests_run++; if (ex_rs1_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lu2_capture got %h exp deadbeef", ex_rs1_data); end
        tests_run++; if (ex_rs2_data !== 32'd0) begin tests_failed++; $display("FAIL lu2_x0_rf got %h exp 0", ex_rs2_data); end
        tests_run++; if (ex_valid !== 1'b1 || ex_pc !== 32'h300) begin tests_failed++; $display("FAIL lu2_latch got %0b/%h exp 1/300", ex_valid, ex_pc); end
        set_idle();
        set_instr(32'h304, OP_REG, 5'd6, 5'd3, 5'd0, 32'd0);
        rf_rs1_data = 32'hAAAA;
        tick();
        tests_run++; if (ex_rs1_data !== 32'hAAAA) begin tests_failed++; $display("FAIL lu2_cap_cleared got %h exp aaaa", ex_rs1_data); end
        $display("[TB] test_load_use_two done");
    endtask

    task automatic test_flush_mem_stall();
        set_idle();
        set_instr(32'h400, OP_IMM, 5'd8, 5'd0, 5'd0, 32'h40);
        tick();
`ifdef DEC_EXEC_PERF_CNT_EN
        sc0 = stall_cycles; bc0 = bubble_count;
`endif
        set_instr(32'h404, OP_IMM, 5'd9, 5'd0, 5'd0, 32'h44);
        mem_stall = 1; flush = 1;
        #1;
        tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL fms_ready_c0 got %0b exp 0", dec_ready); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            flush = 0;
            #1;
            tests_run++; if (ex_pc !== 32'h400 || ex_valid !== 1'b1 || ex_rd !== 5'd8) begin tests_failed++; $display("FAIL fms_hold_c%0d pc/valid/rd got %h/%0b/%0d exp 400/1/8", i, ex_pc, ex_valid, ex_rd); end
            tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL fms_ready_c%0d got %0b exp 0", i, dec_ready); end
        end
        mem_stall = 0;
        #1;
        tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL fms_ready_pend got %0b exp 0", dec_ready); end
        tick();
        tests_run++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin tests_failed++; $display("FAIL fms_bubble got %0b/%0d exp 0/0", ex_valid, ex_rd); end
        tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL fms_ready_after got %0b exp 1", dec_ready); end
`ifdef DEC_EXEC_PERF_CNT_EN
        tests_run++; if (stall_cycles !== sc0 + 32'd4 || bubble_count !== bc0 + 32'd1) begin tests_failed++; $display("FAIL fms_counters got %0d/%0d exp %0d/%0d", stall_cycles, bubble_count, sc0 + 4, bc0 + 1); end
`endif
        set_instr(32'h408, OP_IMM, 5'd10, 5'd0, 5'd0, 32'h48);
        tick();
        tests_run++; if (ex_pc !== 32'h408 || ex_valid !== 1'b1) begin tests_failed++; $display("FAIL fms_resume got %h/%0b exp 408/1", ex_pc, ex_valid); end
        $display("[TB] test_flush_mem_stall done");
    endtask

    task automatic test_flush_hazard();
        set_idle();
        set_instr(32'h500, OP_REG, 5'd11, 5'd6, 5'd0, 32'd0);
        hazard_stall_signal = 0; rs1_fwd_sel = 1; rs1_data_forward = 32'h600D;
        tick();
        flush = 1; rs1_fwd_sel = 0; rs1_data_forward = 32'h0;
        tick();
        tests_run++; if (ex_valid !== 1'b0 || ex_regld !== 1'b0) begin tests_failed++; $display("FAIL fh_bubble got %0b/%0b exp 0/0", ex_valid, ex_regld); end
        flush = 0; hazard_stall_signal = 1;
        set_instr(32'h504, OP_REG, 5'd12, 5'd6, 5'd0, 32'd0);
        rf_rs1_data = 32'h1111;
        #1;
        tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL fh_ready got %0b exp 1", dec_ready); end
        tick();
        tests_run++; if (ex_rs1_data !== 32'h1111 || ex_pc !== 32'h504 || ex_valid !== 1'b1) begin tests_failed++; $display("FAIL fh_rf_after got %h/%h/%0b exp 1111/504/1", ex_rs1_data, ex_pc, ex_valid); end
        $display("[TB] test_flush_hazard done");
    endtask

    task automatic test_freeze_mid_luse();
        set_idle();
        set_instr(32'h600, OP_REG, 5'd13, 5'd7, 5'd0, 32'd0);
        hazard_stall_signal = 0; rs1_fwd_sel = 1; rs1_data_forward = 32'hCAFE;
        tick();
        mem_stall = 1; rs1_fwd_sel = 0; rs1_data_forward = 32'h0;
        tick();
        tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL fz_hold got %0b exp 0", ex_valid); end
        mem_stall = 0; hazard_stall_signal = 1;
        tick();
        tests_run++; if (ex_rs1_data !== 32'hCAFE || ex_pc !== 32'h600 || ex_valid !== 1'b1) begin tests_failed++; $display("FAIL fz_capture got %h/%h/%0b exp cafe/600/1", ex_rs1_data, ex_pc, ex_valid); end
        $display("[TB] test_freeze_mid_luse done");
    endtask

    task automatic test_reset_mid_luse();
        set_idle();
        set_instr(32'h700, OP_REG, 5'd14, 5'd8, 5'd0, 32'h70);
        hazard_stall_signal = 0; rs1_fwd_sel = 1; rs1_data_forward = 32'hFEED;
        tick();
        #2;
        rst = 1;
        #1;
        tests_run++; if (ex_pc !== 32'd0 || ex_rs1_data !== 32'd0 || ex_opcode !== 7'd0) begin tests_failed++; $display("FAIL rml_async got %h/%h/%h exp 0/0/0", ex_pc, ex_rs1_data, ex_opcode); end
`ifdef DEC_EXEC_PERF_CNT_EN
        tests_run++; if (stall_cycles !== 32'd0 || bubble_count !== 32'd0) begin tests_failed++; $display("FAIL rml_counters got %0d/%0d exp 0/0", stall_cycles, bubble_count); end
`endif
        #1;
        rst = 0;
        hazard_stall_signal = 1; rs1_fwd_sel = 0; rs1_data_forward = 32'h0;
        rf_rs1_data = 32'h2222;
        tick();
        tests_run++; if (ex_rs1_data !== 32'h2222 || ex_pc !== 32'h700 || ex_valid !== 1'b1) begin tests_failed++; $display("FAIL rml_rf_after got %h/%h/%0b exp 2222/700/1", ex_rs1_data, ex_pc, ex_valid); end
        $display("[TB] test_reset_mid_luse done");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use_one();
        test_load_use_two();
        test_flush_mem_stall();
        test_flush_hazard();
        test_freeze_mid_luse();
        test_reset_mid_luse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
